uart_tx: RTL and testbench

- UART transmitter: serialises one NB_DATA-bit word per request into a start bit, data bits (LSB first), an optional parity bit and NB_STOP stop bits.
- Bit timing comes from the shared 16x-oversampling baud tick (i_tick, one-cycle pulse at BAUD_RATE*16), the same tick the receive path uses.
- Sits between the TX-side logic (or TX FIFO) and the board TX pin.
- Frame format matches the UART receiver, so the pair loops back cleanly.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - UART transmitter request/serial-line interface
interface uart_tx_if #(
    parameter int NB_DATA = 8
);
    logic               i_tick;
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    logic               o_tx;
    logic               o_tx_busy;
    logic               o_tx_done;

    modport master (
        output i_tick, i_tx_start, i_data,
        input  o_tx, o_tx_busy, o_tx_done
    );

    modport slave (
        input  i_tick, i_tx_start, i_data,
        output o_tx, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter paced by the shared 16x baud tick
module uart_tx #(
    parameter int NB_DATA         = 8,
    parameter int NB_STOP         = 1,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0,
    parameter int N_TICKS         = 16,
    parameter int NB_TICK_COUNTER = $clog2(N_TICKS),
    parameter int NB_DATA_COUNTER = $clog2(NB_DATA)
) (
    input  logic       i_clock,
    input  logic       i_reset,
    uart_tx_if.slave   bus
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    localparam logic [NB_TICK_COUNTER-1:0] TICK_LAST = NB_TICK_COUNTER'(N_TICKS - 1);
    localparam logic [NB_DATA_COUNTER-1:0] IDX_LAST  = NB_DATA_COUNTER'(NB_DATA - 1);
    localparam logic                       STOP_LAST = (NB_STOP > 1);
    localparam logic                       PAR_ODD   = (PARITY_ODD != 0);
    localparam logic                       PAR_EN    = (PARITY_EN != 0);

    state_t                     state_q, state_d;
    logic [NB_DATA-1:0]         shreg_q, shreg_d;
    logic [NB_TICK_COUNTER-1:0] tick_cnt_q, tick_cnt_d;
    logic [NB_DATA_COUNTER-1:0] bit_idx_q, bit_idx_d;
    logic                       stop_cnt_q, stop_cnt_d;
    logic                       parity_q, parity_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       bit_end;

    assign bit_end = bus.i_tick && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        if (state_q != IDLE && bus.i_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_tx_start) begin
                    shreg_d    = bus.i_data;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    parity_d   = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    parity_d  = parity_q ^ shreg_q[0];
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so o_tx stays a clean register output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d ^ PAR_ODD;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = busy_q;
    assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across four frame formats
module tb_uart_tx;
    localparam int NT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       start_r [4];
    logic [7:0] data_r  [4];
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       done_w  [4];

    always #5 clk = ~clk;

    uart_tx_if #(.NB_DATA(8)) if0 ();
    uart_tx_if #(.NB_DATA(8)) if1 ();
    uart_tx_if #(.NB_DATA(8)) if2 ();
    uart_tx_if #(.NB_DATA(8)) if3 ();

    assign if0.i_tick = tick; assign if0.i_tx_start = start_r[0]; assign if0.i_data = data_r[0];
    assign if1.i_tick = tick; assign if1.i_tx_start = start_r[1]; assign if1.i_data = data_r[1];
    assign if2.i_tick = tick; assign if2.i_tx_start = start_r[2]; assign if2.i_data = data_r[2];
    assign if3.i_tick = tick; assign if3.i_tx_start = start_r[3]; assign if3.i_data = data_r[3];
    assign tx_w[0] = if0.o_tx; assign busy_w[0] = if0.o_tx_busy; assign done_w[0] = if0.o_tx_done;
    assign tx_w[1] = if1.o_tx; assign busy_w[1] = if1.o_tx_busy; assign done_w[1] = if1.o_tx_done;
    assign tx_w[2] = if2.o_tx; assign busy_w[2] = if2.o_tx_busy; assign done_w[2] = if2.o_tx_done;
    assign tx_w[3] = if3.o_tx; assign busy_w[3] = if3.o_tx_busy; assign done_w[3] = if3.o_tx_done;

    uart_tx u_dut0 (.i_clock(clk), .i_reset(rst_n), .bus(if0.slave));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (.i_clock(clk), .i_reset(rst_n), .bus(if1.slave));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (.i_clock(clk), .i_reset(rst_n), .bus(if2.slave));
    uart_tx #(.NB_STOP(2)) u_dut3 (.i_clock(clk), .i_reset(rst_n), .bus(if3.slave));

    // Frame format of each instance, as the reference model sees it
    int cfg_par_en  [4] = '{0, 1, 1, 0};
    int cfg_par_odd [4] = '{0, 0, 1, 0};
    int cfg_nstop   [4] = '{1, 1, 1, 2};

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   tick_period = 4;
    int   tick_ph = 0;

    int   m_active [4];
    int   m_ticks  [4];
    int   m_len    [4];
    logic m_bits   [4][0:11];
    logic e_tx [4], e_busy [4], e_done [4];

    logic obs_bits [4][0:11];
    int   obs_done_cnt [4];
    int   busy_ticks [4];
    int   last_done_cyc [4];

    typedef struct {
        int       inst;
        logic [7:0] data;
        int       period;
        int       exp_busy_ticks;
        int       bit_idx;
        logic     exp_bit;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string nm, input int i, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %b expected %b", nm, i, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d", nm, i, act, exp);
        end
    endtask

    task automatic build_frame(input int i, input logic [7:0] d);
        int n;
        n = 0;
        m_bits[i][n++] = 1'b0;
        for (int k = 0; k < 8; k++) m_bits[i][n++] = d[k];
        if (cfg_par_en[i] != 0) m_bits[i][n++] = logic'(($countones(d) + cfg_par_odd[i]) % 2);
        for (int k = 0; k < cfg_nstop[i]; k++) m_bits[i][n++] = 1'b1;
        m_len[i] = n * NT;
    endtask

    task automatic clear_obs(input int i);
        obs_done_cnt[i] = 0;
        busy_ticks[i]   = 0;
        for (int k = 0; k < 12; k++) obs_bits[i][k] = 1'bx;
    endtask

    task automatic cycle();
        logic       s [4];
        logic [7:0] d [4];
        logic       pb [4];
        logic       t, r;
        t = tick;
        r = rst_n;
        for (int i = 0; i < 4; i++) begin
            s[i]  = start_r[i];
            d[i]  = data_r[i];
            pb[i] = busy_w[i];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            e_done[i] = 1'b0;
            if (!r) begin
                m_active[i] = 0;
            end else if (m_active[i] == 0) begin
                if (s[i]) begin
                    build_frame(i, d[i]);
                    m_active[i] = 1;
                    m_ticks[i]  = 0;
                end
            end else if (t) begin
                m_ticks[i]++;
                if (m_ticks[i] == m_len[i]) begin
                    m_active[i] = 0;
                    e_done[i]   = 1'b1;
                end
            end
            e_tx[i]   = (m_active[i] != 0) ? m_bits[i][m_ticks[i] / NT] : 1'b1;
            e_busy[i] = (m_active[i] != 0);
            chk("tx", i, tx_w[i], e_tx[i]);
            chk("busy", i, busy_w[i], e_busy[i]);
            chk("done", i, done_w[i], e_done[i]);
            if (m_active[i] != 0 && (m_ticks[i] % NT) == NT / 2) obs_bits[i][m_ticks[i] / NT] = tx_w[i];
            if (t && pb[i] && r) busy_ticks[i]++;
            if (done_w[i]) begin
                obs_done_cnt[i]++;
                last_done_cyc[i] = cyc;
            end
        end
        tick_ph++;
        tick = ((tick_ph % tick_period) == 0);
    endtask

    task automatic wait_idle(input int i);
        int b;
        b = 0;
        while (m_active[i] != 0 && b < 4000) begin
            cycle();
            b++;
        end
        if (b >= 4000) chk_int("idle_timeout", i, b, 0);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        wait_idle(i);
        start_r[i] = 1'b1;
        data_r[i]  = d;
        cycle();
        start_r[i] = 1'b0;
        data_r[i]  = 8'($urandom);
    endtask

    function automatic logic [7:0] obs_byte(input int i);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = obs_bits[i][k + 1];
        return b;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         i, d1, d2;

        vecs[0] = '{inst: 0, data: 8'h55, period: 4, exp_busy_ticks: 160, bit_idx: 1,  exp_bit: 1'b1};
        vecs[1] = '{inst: 1, data: 8'hA3, period: 2, exp_busy_ticks: 176, bit_idx: 9,  exp_bit: 1'b0};
        vecs[2] = '{inst: 2, data: 8'hA3, period: 2, exp_busy_ticks: 176, bit_idx: 9,  exp_bit: 1'b1};
        vecs[3] = '{inst: 3, data: 8'hFF, period: 1, exp_busy_ticks: 176, bit_idx: 10, exp_bit: 1'b1};
        vecs[4] = '{inst: 0, data: 8'h00, period: 3, exp_busy_ticks: 160, bit_idx: 8,  exp_bit: 1'b0};

        rst_n = 1'b0;
        tick  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start_r[k] = 1'b0;
            data_r[k]  = 8'h00;
            m_active[k] = 0;
            m_ticks[k]  = 0;
            m_len[k]    = 0;
            last_done_cyc[k] = 0;
            clear_obs(k);
        end
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        foreach (vecs[v]) begin
            i = vecs[v].inst;
            tick_period = vecs[v].period;
            wait_idle(i);
            clear_obs(i);
            send(i, vecs[v].data);
            wait_idle(i);
            chk_int("vec_done_count", i, obs_done_cnt[i], 1);
            chk_int("vec_busy_ticks", i, busy_ticks[i], vecs[v].exp_busy_ticks);
            chk("vec_bit", i, obs_bits[i][vecs[v].bit_idx], vecs[v].exp_bit);
            chk_int("vec_data", i, int'(obs_byte(i)), int'(vecs[v].data));
        end

        // Start pulse with new data while busy must be ignored
        tick_period = 1;
        clear_obs(0);
        send(0, 8'h34);
        repeat (40) cycle();
        start_r[0] = 1'b1;
        data_r[0]  = 8'h12;
        cycle();
        start_r[0] = 1'b0;
        data_r[0]  = 8'hEE;
        wait_idle(0);
        repeat (5) cycle();
        chk_int("busy_ignore_done", 0, obs_done_cnt[0], 1);
        chk_int("busy_ignore_data", 0, int'(obs_byte(0)), 32'h34);

        // Back-to-back: accept on the done cycle; accept cycle plus 160 continuous ticks
        clear_obs(0);
        send(0, 8'hFF);
        wait_idle(0);
        d1 = last_done_cyc[0];
        start_r[0] = 1'b1;
        data_r[0]  = 8'h00;
        cycle();
        start_r[0] = 1'b0;
        wait_idle(0);
        d2 = last_done_cyc[0];
        chk_int("b2b_done_count", 0, obs_done_cnt[0], 2);
        chk_int("b2b_done_spacing", 0, d2 - d1, 161);
        chk_int("b2b_second_data", 0, int'(obs_byte(0)), 0);

        // Asynchronous reset during data bit 3
        tick_period = 2;
        clear_obs(0);
        send(0, 8'hA5);
        while (m_active[0] != 0 && m_ticks[0] < 4 * NT + 5) cycle();
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) m_active[k] = 0;
        chk("async_rst_tx", 0, tx_w[0], 1'b1);
        chk("async_rst_busy", 0, busy_w[0], 1'b0);
        chk("async_rst_done", 0, done_w[0], 1'b0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (200) cycle();
        chk_int("rst_no_done", 0, obs_done_cnt[0], 0);
        clear_obs(0);
        send(0, 8'h81);
        wait_idle(0);
        chk_int("post_rst_done", 0, obs_done_cnt[0], 1);
        chk_int("post_rst_data", 0, int'(obs_byte(0)), 32'h81);

        // Randomised frames with spurious start pulses while busy
        for (int r = 0; r < 25; r++) begin
            i = int'($urandom_range(0, 3));
            d = 8'($urandom);
            tick_period = int'($urandom_range(1, 4));
            wait_idle(i);
            clear_obs(i);
            send(i, d);
            while (m_active[i] != 0) begin
                if ($urandom_range(0, 49) == 0) begin
                    start_r[i] = 1'b1;
                    data_r[i]  = 8'($urandom);
                end
                cycle();
                start_r[i] = 1'b0;
            end
            chk_int("rand_done", i, obs_done_cnt[i], 1);
            chk_int("rand_data", i, int'(obs_byte(i)), int'(d));
            chk_int("rand_busy_ticks", i, busy_ticks[i], m_len[i]);
        end
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
